// File: rtl/tia_player.sv
// TIA player object: position counter, HMOVE motion, NUSIZ copy decode and GRP serializer.
// Optional `define TIA_PLAYER_POS_OUT_EN exposes the position counter on pos_dbg.
module tia_player #(
  parameter int START_DELAY = 5,
  parameter int HM_PERIOD   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       phi0,
  input  logic       hblank,
  input  logic       grp_wr,
  input  logic       grp_other_wr,
  input  logic [7:0] d_in,
  input  logic [2:0] nusiz,
  input  logic       refp,
  input  logic       vdel,
  input  logic       resp,
  input  logic       hmove,
  input  logic [3:0] hm,
  output logic       p,
  output logic       center
`ifdef TIA_PLAYER_POS_OUT_EN
  ,
  output logic [7:0] pos_dbg
`endif
);

  localparam int PH_W = (HM_PERIOD > 1) ? $clog2(HM_PERIOD) : 1;

  logic [7:0]             pos_reg;
  logic [3:0]             mc_reg;
  logic [PH_W-1:0]        phase_reg;
  logic [7:0]             grp_new_reg;
  logic [7:0]             grp_old_reg;
  logic [START_DELAY-1:0] start_pipe_reg;
  logic [START_DELAY-1:0] c0_pipe_reg;
  logic                   draw_active_reg;
  logic                   draw_c0_reg;
  logic [2:0]             bit_idx_reg;
  logic [1:0]             sub_reg;
  logic                   p_reg;
  logic                   center_reg;

  logic       phase_last;
  logic       motion_pulse;
  logic       pos_inc;
  logic [7:0] pos_step;
  logic       other_hit;
  logic       adv;
  logic       copy_start;
  logic       copy0_start;
  logic [1:0] scale_last;
  logic       trigger;
  logic       trig_c0;
  logic       active_next;
  logic       c0_next;
  logic [2:0] idx_next;
  logic [1:0] sub_next;
  logic [7:0] grp_sel;
  logic       pix_bit;
  logic       p_next;
  logic       center_next;

  // A pulse is suppressed on the cycle hmove reloads the counter.
  assign phase_last   = (phase_reg == PH_W'(HM_PERIOD - 1));
  assign motion_pulse = (mc_reg != 4'd0) && !hmove && phase_last;
  assign pos_inc      = !hblank || motion_pulse;
  assign pos_step     = (pos_reg == 8'd159) ? 8'd0 : pos_reg + 8'd1;

  always_comb begin
    other_hit = 1'b0;
    case (nusiz)
      3'b001:  other_hit = (pos_step == 8'd16);
      3'b010:  other_hit = (pos_step == 8'd32);
      3'b011:  other_hit = (pos_step == 8'd16) || (pos_step == 8'd32);
      3'b100:  other_hit = (pos_step == 8'd64);
      3'b110:  other_hit = (pos_step == 8'd32) || (pos_step == 8'd64);
      default: other_hit = 1'b0;
    endcase
  end

  // RESP overrides the increment, so it also swallows any start on that cycle.
  assign adv         = !resp && pos_inc;
  assign copy0_start = adv && (pos_step == 8'd0);
  assign copy_start  = adv && ((pos_step == 8'd0) || other_hit);

  always_comb begin
    case (nusiz)
      3'b101:  scale_last = 2'd1;
      3'b111:  scale_last = 2'd3;
      default: scale_last = 2'd0;
    endcase
  end

  assign trigger = start_pipe_reg[START_DELAY-1];
  assign trig_c0 = c0_pipe_reg[START_DELAY-1];

  always_comb begin
    active_next = draw_active_reg;
    c0_next     = draw_c0_reg;
    idx_next    = bit_idx_reg;
    sub_next    = sub_reg;
    if (trigger) begin
      active_next = 1'b1;
      c0_next     = trig_c0;
      idx_next    = 3'd0;
      sub_next    = 2'd0;
    end else if (draw_active_reg) begin
      if (sub_reg >= scale_last) begin
        sub_next = 2'd0;
        if (bit_idx_reg == 3'd7) active_next = 1'b0;
        else                     idx_next    = bit_idx_reg + 3'd1;
      end else begin
        sub_next = sub_reg + 2'd1;
      end
    end
  end

  assign grp_sel     = vdel ? grp_old_reg : grp_new_reg;
  assign pix_bit     = refp ? grp_sel[idx_next] : grp_sel[3'd7 - idx_next];
  assign p_next      = active_next && pix_bit;
  assign center_next = active_next && c0_next && (idx_next == 3'd4) && (sub_next == 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < START_DELAY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            start_pipe_reg[gi] <= 1'b0;
            c0_pipe_reg[gi]    <= 1'b0;
          end else if (phi0) begin
            start_pipe_reg[gi] <= copy_start;
            c0_pipe_reg[gi]    <= copy0_start;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset) begin
            start_pipe_reg[gi] <= 1'b0;
            c0_pipe_reg[gi]    <= 1'b0;
          end else if (phi0) begin
            start_pipe_reg[gi] <= start_pipe_reg[gi-1];
            c0_pipe_reg[gi]    <= c0_pipe_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_reg         <= 8'd0;
      mc_reg          <= 4'd0;
      phase_reg       <= '0;
      grp_new_reg     <= 8'd0;
      grp_old_reg     <= 8'd0;
      draw_active_reg <= 1'b0;
      draw_c0_reg     <= 1'b0;
      bit_idx_reg     <= 3'd0;
      sub_reg         <= 2'd0;
      p_reg           <= 1'b0;
      center_reg      <= 1'b0;
    end else if (phi0) begin
      if (grp_wr)       grp_new_reg <= d_in;
      if (grp_other_wr) grp_old_reg <= grp_new_reg;

      if (hmove) begin
        mc_reg    <= hm ^ 4'b1000;
        phase_reg <= '0;
      end else if (mc_reg != 4'd0) begin
        if (phase_last) begin
          mc_reg    <= mc_reg - 4'd1;
          phase_reg <= '0;
        end else begin
          phase_reg <= phase_reg + PH_W'(1);
        end
      end

      if (resp)         pos_reg <= 8'd0;
      else if (pos_inc) pos_reg <= pos_step;

      draw_active_reg <= active_next;
      draw_c0_reg     <= c0_next;
      bit_idx_reg     <= idx_next;
      sub_reg         <= sub_next;
      p_reg           <= p_next;
      center_reg      <= center_next;
    end
  end

  assign p      = p_reg;
  assign center = center_reg;
`ifdef TIA_PLAYER_POS_OUT_EN
  assign pos_dbg = pos_reg;
`endif

endmodule
